// File: rtl/ll_fifo_mc_scoreboard_if.sv
// Observation bundle between a linked-list FIFO bench and its magic-packet scoreboard.
// No latency of its own; it only carries nets.
// No backpressure: the scoreboard passively watches and never stalls the FIFO.
interface ll_fifo_mc_scoreboard_if #(
  parameter int WIDTH     = 4,
  parameter int NUM_FIFOS = 2
);
  localparam int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

  // FIFO traffic and capture request, driven by the bench / FIFO side
  logic                 push;
  logic                 pop;
  logic [SEL_WIDTH-1:0] push_sel;
  logic [SEL_WIDTH-1:0] pop_sel;
  logic [WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]     data_out;
  logic                 start;
  logic [SEL_WIDTH-1:0] watch_sel;

  // Scoreboard status
  logic                 armed;
  logic [SEL_WIDTH-1:0] trk_chan;
  logic                 data_out_vld;
  logic                 prop_signal;
  logic                 done;
  logic                 err_ovf;
  logic                 err_udf;

  modport master (
    output push, pop, push_sel, pop_sel, data_in, data_out, start, watch_sel,
    input  armed, trk_chan, data_out_vld, prop_signal, done, err_ovf, err_udf
  );

  modport slave (
    input  push, pop, push_sel, pop_sel, data_in, data_out, start, watch_sel,
    output armed, trk_chan, data_out_vld, prop_signal, done, err_ovf, err_udf
  );
endinterface

// File: rtl/ll_fifo_mc_scoreboard.sv
// Multi-channel magic-packet scoreboard: captures one word on a watched channel and checks it on exit.
// data_out_vld/prop_signal are combinational with pop; done follows the magic pop by one cycle.
// Never backpressures; overflow/underflow are flagged sticky and the counters saturate.
module ll_fifo_mc_scoreboard #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int NUM_FIFOS = 2,
  parameter int REARM     = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  ll_fifo_mc_scoreboard_if.slave sb
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int CW        = PTR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q [NUM_FIFOS];
  logic [CW-1:0]        cnt_d [NUM_FIFOS];
  logic [CW-1:0]        tot_q, tot_d;
  logic [CW-1:0]        ahead_q, ahead_d;
  logic [WIDTH-1:0]     magic_q, magic_d;
  logic [SEL_WIDTH-1:0] trk_q, trk_d;
  logic                 ovf_q, udf_q;

  logic [CW-1:0]        cnt_pop, cnt_push;
  logic                 full, pop_eff, push_eff;
  logic                 ovf_set, udf_set;
  logic                 cap, trk_pop, vld;

  // Occupancy of the channels addressed by this cycle's push and pop
  always_comb begin
    cnt_pop  = '0;
    cnt_push = '0;
    for (int c = 0; c < NUM_FIFOS; c++) begin
      if (sb.pop_sel == SEL_WIDTH'(c))  cnt_pop  = cnt_q[c];
      if (sb.push_sel == SEL_WIDTH'(c)) cnt_push = cnt_q[c];
    end
  end

  // A pop of an empty channel or a push into a full FIFO is ignored by the counters
  assign full     = (tot_q == DEPTH_C);
  assign pop_eff  = sb.pop & (cnt_pop != '0);
  assign push_eff = sb.push & (~full | pop_eff);
  assign ovf_set  = sb.push & full & ~sb.pop;
  assign udf_set  = sb.pop & (cnt_pop == '0);

  // Next-state occupancy per channel and in total
  always_comb begin
    tot_d = tot_q;
    if (push_eff && !pop_eff)      tot_d = tot_q + ONE_C;
    else if (pop_eff && !push_eff) tot_d = tot_q - ONE_C;
    for (int c = 0; c < NUM_FIFOS; c++) begin
      cnt_d[c] = cnt_q[c];
      if ((push_eff && sb.push_sel == SEL_WIDTH'(c)) && !(pop_eff && sb.pop_sel == SEL_WIDTH'(c)))
        cnt_d[c] = cnt_q[c] + ONE_C;
      else if ((pop_eff && sb.pop_sel == SEL_WIDTH'(c)) && !(push_eff && sb.push_sel == SEL_WIDTH'(c)))
        cnt_d[c] = cnt_q[c] - ONE_C;
    end
  end

  assign cap     = sb.start & sb.push & (sb.push_sel == sb.watch_sel);
  assign trk_pop = sb.pop & (sb.pop_sel == trk_q);

  // Capture/track/check sequencing; ahead counts entries still in front of the magic word
  always_comb begin
    state_d = state_q;
    ahead_d = ahead_q;
    magic_d = magic_q;
    trk_d   = trk_q;
    vld     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = ARMED;
          magic_d = sb.data_in;
          trk_d   = sb.push_sel;
          // a same-channel pop in the capture cycle removes one entry from in front
          ahead_d = cnt_push - ((pop_eff && sb.pop_sel == sb.push_sel) ? ONE_C : '0);
        end
      end
      ARMED: begin
        if (trk_pop) begin
          if (ahead_q == '0) begin
            vld     = 1'b1;
            state_d = DONE;
          end else begin
            ahead_d = ahead_q - ONE_C;
          end
        end
      end
      DONE: begin
        if (REARM != 0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ahead_q <= '0;
      magic_q <= '0;
      trk_q   <= '0;
    end else begin
      state_q <= state_d;
      ahead_q <= ahead_d;
      magic_q <= magic_d;
      trk_q   <= trk_d;
    end
  end

  // Occupancy counters, tracked in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tot_q <= '0;
      for (int c = 0; c < NUM_FIFOS; c++) cnt_q[c] <= '0;
    end else begin
      tot_q <= tot_d;
      for (int c = 0; c < NUM_FIFOS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  // Sticky protocol-violation flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      udf_q <= udf_q | udf_set;
    end
  end

  assign sb.armed        = (state_q == ARMED);
  assign sb.done         = (state_q == DONE);
  assign sb.trk_chan     = trk_q;
  assign sb.data_out_vld = vld;
  assign sb.prop_signal  = ~vld | (sb.data_out == magic_q);
  assign sb.err_ovf      = ovf_q;
  assign sb.err_udf      = udf_q;
endmodule

// File: tb/tb_ll_fifo_mc_scoreboard.sv
// Bench for ll_fifo_mc_scoreboard: one-shot and re-arm instances watch the same traffic.
// A FIFO-content model tags the magic entry; expected outputs go through a scoreboard queue.
// Stimulus is fixed; every step is a single clock.
module tb_ll_fifo_mc_scoreboard;
  logic clk;
  logic rst_n;
  logic push, pop, start;
  logic [0:0] push_sel, pop_sel, watch_sel;
  logic [3:0] data_in, data_out;

  int total = 0;
  int bad   = 0;

  ll_fifo_mc_scoreboard_if #(.WIDTH(4), .NUM_FIFOS(2)) sb0_if ();
  ll_fifo_mc_scoreboard_if #(.WIDTH(4), .NUM_FIFOS(2)) sb1_if ();

  assign sb0_if.push = push;           assign sb1_if.push = push;
  assign sb0_if.pop = pop;             assign sb1_if.pop = pop;
  assign sb0_if.push_sel = push_sel;   assign sb1_if.push_sel = push_sel;
  assign sb0_if.pop_sel = pop_sel;     assign sb1_if.pop_sel = pop_sel;
  assign sb0_if.data_in = data_in;     assign sb1_if.data_in = data_in;
  assign sb0_if.data_out = data_out;   assign sb1_if.data_out = data_out;
  assign sb0_if.start = start;         assign sb1_if.start = start;
  assign sb0_if.watch_sel = watch_sel; assign sb1_if.watch_sel = watch_sel;

  ll_fifo_mc_scoreboard #(.WIDTH(4), .DEPTH(4), .NUM_FIFOS(2), .REARM(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sb(sb0_if));
  ll_fifo_mc_scoreboard #(.WIDTH(4), .DEPTH(4), .NUM_FIFOS(2), .REARM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sb(sb1_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: FIFO contents with a per-config magic tag, plus expected status
  typedef struct {
    logic [3:0] d;
    bit   [1:0] tag;
  } ent_t;
  ent_t q0[$];
  ent_t q1[$];
  bit         m_armed [2];
  bit         m_done  [2];
  logic [3:0] m_magic [2];
  bit         m_trk   [2];
  bit         m_ovf, m_udf;
  // {armed, done, data_out_vld, prop_signal, err_ovf, err_udf, trk_chan}
  logic [6:0] exp_q[$];
  localparam logic [6:0] RST_OBS = 7'b0001000;
  int step_no = 0;

  function automatic logic [6:0] obs(input int r);
    if (r == 0)
      return {sb0_if.armed, sb0_if.done, sb0_if.data_out_vld, sb0_if.prop_signal,
              sb0_if.err_ovf, sb0_if.err_udf, sb0_if.trk_chan};
    return {sb1_if.armed, sb1_if.done, sb1_if.data_out_vld, sb1_if.prop_signal,
            sb1_if.err_ovf, sb1_if.err_udf, sb1_if.trk_chan};
  endfunction

  task automatic clear_model();
    q0.delete();
    q1.delete();
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      m_armed[r] = 0; m_done[r] = 0; m_magic[r] = 4'h0; m_trk[r] = 0;
    end
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic idle_inputs();
    push = 0; pop = 0; start = 0;
    push_sel = 0; pop_sel = 0; watch_sel = 0;
    data_in = 4'h0; data_out = 4'h0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    idle_inputs();
    clear_model();
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of traffic, called at a falling edge; frc overrides data_out
  task automatic step(input bit pu, input int ps, input logic [3:0] di, input bit st,
                      input int ws, input bit po, input int pos, input bit frc,
                      input logic [3:0] fdo);
    ent_t fr;
    bit have;
    bit [1:0] cap;
    int tot_before;
    logic [6:0] e;
    logic [6:0] a;
    bit v;
    push = pu; push_sel = ps[0]; data_in = di; start = st; watch_sel = ws[0];
    pop = po; pop_sel = pos[0];
    have = 0;
    fr.d = 4'h0; fr.tag = 2'b00;
    if (po && pos == 0 && q0.size() > 0) begin fr = q0[0]; have = 1; end
    if (po && pos == 1 && q1.size() > 0) begin fr = q1[0]; have = 1; end
    data_out = frc ? fdo : fr.d;
    for (int r = 0; r < 2; r++) begin
      v = have && fr.tag[r];
      e = {m_armed[r], m_done[r], v, (!v || data_out == m_magic[r]), m_ovf, m_udf, m_trk[r]};
      exp_q.push_back(e);
    end
    #1;
    for (int r = 0; r < 2; r++) begin
      e = exp_q.pop_front();
      a = obs(r);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL step%0d cfg_rearm%0d status {arm,done,vld,prop,ovf,udf,trk}: got %b want %b",
                 step_no, r, a, e);
      end
    end
    step_no++;
    @(posedge clk);
    tot_before = q0.size() + q1.size();
    for (int r = 0; r < 2; r++) begin
      cap[r] = st && pu && (ps == ws) && !m_armed[r] && !m_done[r];
      if (r == 1 && m_done[1]) m_done[1] = 0;
      if (have && fr.tag[r]) begin m_armed[r] = 0; m_done[r] = 1; end
    end
    if (po) begin
      if (!have) m_udf = 1;
      else if (pos == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
    if (pu && tot_before == 4 && !po) m_ovf = 1;
    if (pu && (tot_before < 4 || have)) begin
      fr.d = di; fr.tag = cap;
      if (ps == 0) q0.push_back(fr); else q1.push_back(fr);
    end
    for (int r = 0; r < 2; r++)
      if (cap[r]) begin m_armed[r] = 1; m_magic[r] = di; m_trk[r] = ps[0]; end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0);
  endtask

  task automatic test_reset();
    assert_reset();
    #1;
    for (int r = 0; r < 2; r++) begin
      total++;
      if (obs(r) !== RST_OBS) begin
        bad++;
        $display("FAIL reset_values cfg%0d: got %b want %b", r, obs(r), RST_OBS);
      end
    end
    release_reset();
    idle();
  endtask

  task automatic test_empty_channel();
    assert_reset();
    release_reset();
    step(1, 1, 4'h3, 1, 1, 0, 0, 0, 4'h0);
    total++;
    if (sb0_if.armed !== 1'b1 || sb0_if.trk_chan !== 1'b1) begin
      bad++;
      $display("FAIL capture_ch1 armed/trk: got %b/%b want 1/1", sb0_if.armed, sb0_if.trk_chan);
    end
    step(0, 0, 4'h0, 0, 0, 1, 1, 0, 4'h0);
    total++;
    if (sb0_if.done !== 1'b1 || sb1_if.done !== 1'b1) begin
      bad++;
      $display("FAIL done_after_pop: got %b/%b want 1/1", sb0_if.done, sb1_if.done);
    end
    idle();
  endtask

  task automatic test_ahead_same_cycle_pop();
    assert_reset();
    release_reset();
    step(1, 0, 4'h1, 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 4'h2, 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 4'h9, 1, 0, 1, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'h0);
    total++;
    if (sb0_if.armed !== 1'b1) begin
      bad++;
      $display("FAIL ahead_first_pop armed: got %b want 1", sb0_if.armed);
    end
    step(0, 0, 4'h0, 0, 0, 1, 0, 1, 4'hA);
    idle();
  endtask

  task automatic test_interleave();
    assert_reset();
    release_reset();
    step(1, 0, 4'h5, 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 4'h6, 1, 0, 0, 0, 0, 4'h0);
    step(1, 1, 4'hA, 1, 1, 0, 0, 0, 4'h0);
    step(1, 1, 4'hB, 0, 0, 1, 1, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 1, 0, 4'h6);
    step(1, 0, 4'h7, 0, 0, 0, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'h0);
    idle();
  endtask

  task automatic test_back_to_back();
    int pulses;
    assert_reset();
    release_reset();
    pulses = 0;
    step(1, 1, 4'h5, 1, 1, 0, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 1, 0, 4'h0);
    pulses += int'(sb1_if.done);
    idle();
    pulses += int'(sb1_if.done);
    step(1, 1, 4'h6, 1, 1, 0, 0, 0, 4'h0);
    total++;
    if (sb1_if.armed !== 1'b1 || sb0_if.armed !== 1'b0 || sb0_if.done !== 1'b1) begin
      bad++;
      $display("FAIL second_capture rearm.armed/oneshot.armed/oneshot.done: got %b%b%b want 101",
               sb1_if.armed, sb0_if.armed, sb0_if.done);
    end
    step(0, 0, 4'h0, 0, 0, 1, 1, 0, 4'h0);
    pulses += int'(sb1_if.done);
    idle();
    pulses += int'(sb1_if.done);
    idle();
    total++;
    if (pulses !== 2) begin
      bad++;
      $display("FAIL rearm_done_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_errors();
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 4'(i + 1), 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 4'hE, 0, 0, 0, 0, 0, 4'h0);
    total++;
    if (sb0_if.err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL overflow_flag: got %b want 1", sb0_if.err_ovf);
    end
    step(0, 0, 4'h0, 0, 0, 1, 1, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'h0);
    step(1, 1, 4'hC, 1, 1, 0, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 1, 1, 0, 4'h0);
    idle();
    total++;
    if (sb1_if.err_ovf !== 1'b1 || sb1_if.err_udf !== 1'b1) begin
      bad++;
      $display("FAIL sticky_errors: got %b%b want 11", sb1_if.err_ovf, sb1_if.err_udf);
    end
  endtask

  task automatic test_reset_mid_armed();
    assert_reset();
    release_reset();
    step(1, 0, 4'h1, 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 4'h2, 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 4'h8, 1, 0, 0, 0, 0, 4'h0);
    #2;
    assert_reset();
    #1;
    for (int r = 0; r < 2; r++) begin
      total++;
      if (obs(r) !== RST_OBS) begin
        bad++;
        $display("FAIL async_reset_armed cfg%0d: got %b want %b", r, obs(r), RST_OBS);
      end
    end
    release_reset();
    step(0, 0, 4'h0, 0, 0, 1, 0, 1, 4'h8);
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    clear_model();
    @(negedge clk);
    test_reset();
    test_empty_channel();
    test_ahead_same_cycle_pop();
    test_interleave();
    test_back_to_back();
    test_errors();
    test_reset_mid_armed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ll_fifo_mc_scoreboard.md
# ll_fifo_mc_scoreboard

Multi-channel magic-packet scoreboard for the shared linked-list FIFO: it watches the push/pop traffic of all NUM_FIFOS logical queues, captures one "magic" word on a chosen channel, counts the entries ahead of it, and flags whether the word leaving that channel at the matching pop equals the captured value. It is the successor of the single-channel in-line scoreboard in the refinement-proof top. It adds run-time channel selection, an optional re-arm mode for repeated captures, and sticky protocol-violation flags, so one instance covers every queue in a proof or simulation bench.

## Interface
- WIDTH, 4: data word width.
- DEPTH, 2: total shared FIFO capacity (entries across all channels).
- NUM_FIFOS, 2: number of logical channels.
- REARM, 0: 0 = one-shot (stay DONE until reset); 1 = return to IDLE after each check.
- PTR_WIDTH, $clog2(DEPTH); SEL_WIDTH, max(1,$clog2(NUM_FIFOS)): derived, do not override.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push, pop  in  1  DUT push/pop strobes, same cycle as DUT.
- push_sel, pop_sel  in  SEL_WIDTH  channel of push/pop.
- data_in  in  WIDTH  DUT write data.
- data_out  in  WIDTH  DUT read data (combinationally valid with pop).
- start  in  1  capture request; qualified by push on watch_sel.
- watch_sel  in  SEL_WIDTH  channel eligible for capture.
- armed  out  1  state == ARMED.
- trk_chan  out  SEL_WIDTH  latched channel of the magic packet.
- data_out_vld  out  1  current pop is the magic packet.
- prop_signal  out  1  !data_out_vld | (data_out == magic).
- done  out  1  pulse (REARM=1) / level (REARM=0) after check.
- err_ovf, err_udf  out  1  sticky: push while full / pop of empty channel.

## Operation
- Per-channel counters cnt[c], PTR_WIDTH+1 bits, and total tot = sum, maintained in every state: cnt[c] += (push & push_sel==c) - (pop & pop_sel==c). Push and pop on the same channel in one cycle leave it unchanged.
- err_ovf sets on push & (tot==DEPTH) & !pop. err_udf sets on pop & cnt[pop_sel]==0. Both are sticky until reset. On a violation the counters saturate at DEPTH / 0 and do not wrap.
- FSM states IDLE, ARMED, DONE.
- IDLE -> ARMED when cap = start & push & push_sel==watch_sel. On cap:
  - magic <= data_in, trk_chan <= push_sel.
  - ahead <= cnt[push_sel] - (pop & pop_sel==push_sel), which counts entries strictly ahead of the magic word.
- ARMED, on pop & pop_sel==trk_chan:
  - ahead==0: data_out_vld=1 this cycle, and the state moves to DONE.
  - otherwise: ahead <= ahead-1.
- Pushes on trk_chan while ARMED do not change ahead. start is ignored outside IDLE.
- DONE: REARM=1 -> IDLE next cycle, with done high for that one DONE cycle. REARM=0 -> holds DONE, done stays high.
- data_out_vld = armed & pop & pop_sel==trk_chan & ahead==0 (combinational). prop_signal is combinational from data_out_vld, data_out and magic.
- Capture and the magic pop never coincide, because the magic word is at least one cycle in the FIFO.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE; cnt, tot, ahead 0; magic 0; trk_chan 0.
  - armed 0, data_out_vld 0, prop_signal 1, done 0, err_ovf 0, err_udf 0.
- Capture registers on the cap edge, and armed goes high the following cycle.
- Minimum capture-to-check latency is one cycle (empty channel, pop next cycle).
- data_out_vld and prop_signal have zero latency relative to pop. done rises on the cycle after the magic pop.
- rst_n asserted mid-ARMED discards the capture immediately, and no check is made.

## Test plan
- NUM_FIFOS=2, DEPTH=4: push ch1 0x3 with start, watch_sel=1, channel empty; pop ch1 next cycle with data_out=0x3 -> data_out_vld=1, prop_signal=1, done=1 next cycle.
- Push ch0 0x1 and ch0 0x2. Then push ch0 0x9 with start while popping ch0 in the same cycle. Expected: ahead=1, the first following ch0 pop gives data_out_vld=0, the second gives data_out_vld=1. With data_out=0xA: prop_signal=0.
- Interleave ch1 pushes and pops while tracking ch0 -> ahead is unchanged, and data_out_vld never asserts on ch1 pops.
- REARM=1: complete two captures back-to-back (0x5, then 0x6) -> done pulses once each, and armed returns high for the second. REARM=0: a second start is ignored and done stays high.
- Fill tot to 4 and push without pop -> err_ovf=1, sticky. Pop an empty ch1 -> err_udf=1, and cnt[1] stays 0.
- Deassert rst_n while ARMED with ahead=2 -> all outputs return to reset values asynchronously, and a later magic pop gives data_out_vld=0.
